// File: rtl/d20_pkg.sv
// Shared types and helpers for the d20 dice engine: roll modes, FSM states,
// the entry-to-face mapping and signed saturation.
package d20_pkg;

  typedef enum logic [1:0] {
    MODE_SUM = 2'd0,
    MODE_ADV = 2'd1,
    MODE_DIS = 2'd2
  } roll_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRAW    = 2'd1,
    ST_RESOLVE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Seed entries span 0..2^ENTRY_W-1, which is below 2*sides, so a single
  // subtract folds the upper range back onto 1..sides.
  function automatic int face_of(input int v, input int sides);
    return (v >= sides) ? (v - sides + 1) : (v + 1);
  endfunction

  // Clamp a signed value into the range of a bits-wide two's complement word.
  function automatic int sat_signed(input int x, input int bits);
    int hi;
    int lo;
    hi = (1 << (bits - 1)) - 1;
    lo = -(1 << (bits - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/d20_seed_table.sv
// Host-loaded entropy table: write port, "fully loaded" flag and a wrapping
// read pointer that steps once per die drawn.
module d20_seed_table
  import d20_pkg::*;
#(
  parameter int DEPTH   = 32,
  parameter int ENTRY_W = 5,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               write,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [ENTRY_W-1:0] data,
  input  logic               advance,
  output logic [ENTRY_W-1:0] rd_data,
  output logic               loaded
);

  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]  rd_ptr;
  logic               in_range;

  assign in_range = ({1'b0, addr} < DEPTH_L);

  // Table storage write port.
  // NOTE: the memory has no reset on purpose; contents survive reset and only
  // the loaded flag is cleared, which is what forces a reload.
  always_ff @(posedge clk) begin
    if (write && in_range) mem[addr] <= data;
  end

  // Loaded flag and wrapping read pointer.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      loaded <= 1'b0;
      rd_ptr <= '0;
    end else begin
      if (write && addr == LAST) loaded <= 1'b1;
      if (advance) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + ADDR_W'(1);
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/d20_dice_engine.sv
// Dice engine top: accepts a roll request, draws N dice from the seed table,
// adds a signed modifier with saturation and compares against a target.
module d20_dice_engine
  import d20_pkg::*;
#(
  parameter int NUM_BITS    = 8,
  parameter int DIE_SIDES   = 20,
  parameter int MAX_DICE    = 4,
  parameter int TABLE_DEPTH = 32,
  localparam int ENTRY_W = $clog2(DIE_SIDES),
  localparam int FACE_W  = $clog2(DIE_SIDES + 1),
  localparam int ADDR_W  = $clog2(TABLE_DEPTH),
  localparam int DICE_W  = $clog2(MAX_DICE + 1),
  localparam int SUM_W   = $clog2(MAX_DICE * DIE_SIDES + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       write,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [ENTRY_W-1:0]         data,
  input  logic                       next,
  input  logic [1:0]                 mode,
  input  logic [DICE_W-1:0]          num_dice,
  input  logic signed [NUM_BITS-1:0] mod,
  input  logic signed [NUM_BITS-1:0] target,
  output logic                       ready,
  output logic                       valid,
  output logic [FACE_W-1:0]          random_num,
  output logic [SUM_W-1:0]           die_sum,
  output logic signed [NUM_BITS-1:0] final_num,
  output logic                       hit,
  output logic                       crit_hit,
  output logic                       crit_miss
);

  localparam int WIDE_W = NUM_BITS + SUM_W + 1;
  localparam logic [DICE_W-1:0] MAX_L   = DICE_W'(MAX_DICE);
  localparam logic [DICE_W-1:0] ONE_D   = DICE_W'(1);
  localparam logic [FACE_W-1:0] SIDES_F = FACE_W'(DIE_SIDES);
  localparam logic [FACE_W-1:0] ONE_F   = FACE_W'(1);

  state_t                     state_q, state_d;
  roll_mode_t                 mode_q, mode_in;
  logic [DICE_W-1:0]          n_q, n_in, cnt_q;
  logic signed [NUM_BITS-1:0] mod_q, target_q;
  logic [SUM_W-1:0]           sum_q, total;
  logic [FACE_W-1:0]          keep_q, face;
  logic [ENTRY_W-1:0]         rd_data;
  logic                       loaded, accept, tbl_write, draw, last_draw, crit_ok;
  logic signed [WIDE_W-1:0]   wide;
  logic signed [NUM_BITS-1:0] final_calc, res_final;
  logic                       res_hit, res_ch, res_cm;

  assign ready     = loaded && (state_q == ST_IDLE) && !write;
  assign accept    = next && ready;
  assign tbl_write = write && (state_q == ST_IDLE);
  assign draw      = (state_q == ST_DRAW);
  assign last_draw = (cnt_q == n_q - ONE_D);
  assign face      = FACE_W'(face_of(int'(rd_data), DIE_SIDES));

  d20_seed_table #(
    .DEPTH   (TABLE_DEPTH),
    .ENTRY_W (ENTRY_W),
    .ADDR_W  (ADDR_W)
  ) u_table (
    .clk     (clk),
    .reset   (reset),
    .write   (tbl_write),
    .addr    (addr),
    .data    (data),
    .advance (draw),
    .rd_data (rd_data),
    .loaded  (loaded)
  );

  // Decode the requested mode and dice count into what the roll will use.
  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned and infers a latch.
  always_comb begin
    mode_in = MODE_SUM;
    n_in    = ONE_D;
    case (mode)
      2'd1: begin
        mode_in = MODE_ADV;
        n_in    = DICE_W'(2);
      end
      2'd2: begin
        mode_in = MODE_DIS;
        n_in    = DICE_W'(2);
      end
      default: begin
        if (num_dice == '0)        n_in = ONE_D;
        else if (num_dice > MAX_L) n_in = MAX_L;
        else                       n_in = num_dice;
      end
    endcase
  end

  // Result arithmetic: widen, add the modifier, saturate, compare.
  always_comb begin
    total      = (mode_q == MODE_SUM) ? sum_q : SUM_W'(keep_q);
    wide       = $signed({{(NUM_BITS + 1){1'b0}}, total})
               + $signed({{(SUM_W + 1){mod_q[NUM_BITS-1]}}, mod_q});
    final_calc = NUM_BITS'(sat_signed(int'(wide), NUM_BITS));
    crit_ok    = (mode_q != MODE_SUM) || (n_q == ONE_D);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (accept) state_d = ST_DRAW;
      ST_DRAW:    if (last_draw) state_d = ST_RESOLVE;
      ST_RESOLVE: state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Roll datapath: latch request, accumulate dice, resolve, publish outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q     <= MODE_SUM;
      n_q        <= ONE_D;
      cnt_q      <= '0;
      mod_q      <= '0;
      target_q   <= '0;
      sum_q      <= '0;
      keep_q     <= '0;
      res_final  <= '0;
      res_hit    <= 1'b0;
      res_ch     <= 1'b0;
      res_cm     <= 1'b0;
      valid      <= 1'b0;
      random_num <= '0;
      die_sum    <= '0;
      final_num  <= '0;
      hit        <= 1'b0;
      crit_hit   <= 1'b0;
      crit_miss  <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            mode_q   <= mode_in;
            n_q      <= n_in;
            mod_q    <= mod;
            target_q <= target;
            cnt_q    <= '0;
          end
        end
        ST_DRAW: begin
          cnt_q <= cnt_q + ONE_D;
          if (cnt_q == '0) begin
            sum_q  <= SUM_W'(face);
            keep_q <= face;
          end else begin
            sum_q <= sum_q + SUM_W'(face);
            case (mode_q)
              MODE_ADV: if (face > keep_q) keep_q <= face;
              MODE_DIS: if (face < keep_q) keep_q <= face;
              default:  keep_q <= face;
            endcase
          end
        end
        ST_RESOLVE: begin
          res_final <= final_calc;
          res_hit   <= (final_calc >= target_q);
          res_ch    <= crit_ok && (keep_q == SIDES_F);
          res_cm    <= crit_ok && (keep_q == ONE_F);
        end
        ST_DONE: begin
          valid      <= 1'b1;
          random_num <= keep_q;
          die_sum    <= total;
          final_num  <= res_final;
          hit        <= res_hit;
          crit_hit   <= res_ch;
          crit_miss  <= res_cm;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_d20_dice_engine.sv
// Scoreboard bench for d20_dice_engine: rolls push hand-computed results,
// a negedge monitor pops and compares whenever valid is seen.
module tb_d20_dice_engine;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              write = 1'b0;
  logic [4:0]        addr = '0;
  logic [4:0]        data = '0;
  logic              next = 1'b0;
  logic [1:0]        mode = '0;
  logic [2:0]        num_dice = '0;
  logic signed [7:0] mod = '0;
  logic signed [7:0] target = '0;
  logic              ready, valid, hit, crit_hit, crit_miss;
  logic [4:0]        random_num;
  logic [6:0]        die_sum;
  logic signed [7:0] final_num;

  d20_dice_engine dut (
    .clk        (clk),
    .reset      (reset),
    .write      (write),
    .addr       (addr),
    .data       (data),
    .next       (next),
    .mode       (mode),
    .num_dice   (num_dice),
    .mod        (mod),
    .target     (target),
    .ready      (ready),
    .valid      (valid),
    .random_num (random_num),
    .die_sum    (die_sum),
    .final_num  (final_num),
    .hit        (hit),
    .crit_hit   (crit_hit),
    .crit_miss  (crit_miss)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int id;
    int rn;
    int sum;
    int fin;
    int hit;
    int ch;
    int cm;
    int due;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   tbl[32];

  int s8[8]    = '{10, 26, 42, 58, 74, 10, 26, 42};
  int last8[8] = '{4, 8, 12, 16, 20, 4, 8, 12};
  int hit8[8]  = '{0, 0, 1, 1, 1, 0, 0, 1};

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every valid pulse must match the oldest outstanding roll.
  always @(negedge clk) begin
    exp_t e;
    if (valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        check($sformatf("r%0d.random_num", e.id), int'(random_num), e.rn);
        check($sformatf("r%0d.die_sum", e.id), int'(die_sum), e.sum);
        check($sformatf("r%0d.final_num", e.id), int'(final_num), e.fin);
        check($sformatf("r%0d.hit", e.id), int'(hit), e.hit);
        check($sformatf("r%0d.crit_hit", e.id), int'(crit_hit), e.ch);
        check($sformatf("r%0d.crit_miss", e.id), int'(crit_miss), e.cm);
        check($sformatf("r%0d.latency", e.id), cyc, e.due);
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready) check("ready_timeout", 0, 1);
  endtask

  // Issue one roll; nused is the dice count the engine should draw.
  task automatic roll(input int id, input int m, input int nd, input int md,
                      input int tg, input int nused, input int rn, input int sum,
                      input int fin, input int h, input int ch, input int cm);
    exp_t e;
    wait_ready();
    mode     = 2'(m);
    num_dice = 3'(nd);
    mod      = 8'(md);
    target   = 8'(tg);
    next     = 1'b1;
    @(posedge clk);
    #1;
    next     = 1'b0;
    e.id  = id;
    e.rn  = rn;
    e.sum = sum;
    e.fin = fin;
    e.hit = h;
    e.ch  = ch;
    e.cm  = cm;
    e.due = cyc + nused + 2;
    sb.push_back(e);
    // Scramble inputs mid-roll; the latched request must be unaffected.
    mode     = 2'(m + 1);
    num_dice = 3'(nd + 3);
    mod      = 8'(md + 37);
    target   = ~target;
  endtask

  task automatic load_table();
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      write = 1'b1;
      addr  = 5'(i);
      data  = 5'(tbl[i]);
    end
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
  endtask

  task automatic set_identity();
    for (int i = 0; i < 32; i++) tbl[i] = i;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst.ready", int'(ready), 0);
    check("rst.valid", int'(valid), 0);
    check("rst.random_num", int'(random_num), 0);
    check("rst.final_num", int'(final_num), 0);
    reset = 1'b0;
    @(negedge clk);
    check("unloaded.ready", int'(ready), 0);

    // T1/T2: identity table
    set_identity();
    load_table();
    #1;
    check("loaded.ready", int'(ready), 1);
    roll(1, 0, 1, 5, 10, 1, 1, 1, 6, 0, 0, 1);
    roll(2, 0, 3, -3, 0, 3, 4, 9, 6, 1, 0, 0);
    drain();

    // T3: advantage then disadvantage on entries 19,3
    tbl[0] = 19;
    tbl[1] = 3;
    do_reset();
    load_table();
    roll(3, 1, 4, 0, 10, 2, 20, 20, 20, 1, 1, 0);
    drain();
    do_reset();
    load_table();
    roll(4, 2, 1, 0, 10, 2, 4, 4, 4, 0, 0, 0);
    drain();

    // T4: all-max table, positive saturation and large negative modifier
    for (int i = 0; i < 32; i++) tbl[i] = 19;
    do_reset();
    load_table();
    roll(5, 0, 4, 127, 127, 4, 20, 80, 127, 1, 0, 0);
    roll(6, 0, 1, -128, 0, 1, 20, 20, -108, 0, 1, 0);
    drain();

    // T5: pointer wrap and num_dice / mode edge cases
    set_identity();
    do_reset();
    load_table();
    for (int j = 0; j < 8; j++)
      roll(10 + j, 0, 4, 0, 40, 4, last8[j], s8[j], s8[j], hit8[j], 0, 0);
    roll(20, 0, 1, 0, 1, 1, 1, 1, 1, 1, 0, 1);
    roll(21, 0, 0, 0, 5, 1, 2, 2, 2, 0, 0, 0);
    roll(22, 3, 1, 0, 0, 1, 3, 3, 3, 1, 0, 0);
    roll(23, 0, 7, -10, 10, 4, 7, 22, 12, 1, 0, 0);
    drain();

    // T6: reset mid-roll, reload gating, write+next collision
    wait_ready();
    mode     = 2'd0;
    num_dice = 3'd4;
    mod      = 8'sd0;
    next     = 1'b1;
    @(posedge clk);
    #1;
    next = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("abort.valid", int'(valid), 0);
    check("abort.ready", int'(ready), 0);
    check("abort.random_num", int'(random_num), 0);
    check("abort.die_sum", int'(die_sum), 0);
    check("abort.hit", int'(hit), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("abort.ready_after", int'(ready), 0);
    write = 1'b1;
    addr  = 5'd31;
    data  = 5'd31;
    #1;
    check("reload.ready_during_write", int'(ready), 0);
    @(negedge clk);
    write = 1'b0;
    #1;
    check("reload.ready", int'(ready), 1);
    @(negedge clk);
    write = 1'b1;
    addr  = 5'd5;
    data  = 5'd5;
    next  = 1'b1;
    #1;
    check("collide.ready", int'(ready), 0);
    @(negedge clk);
    write = 1'b0;
    next  = 1'b0;
    repeat (10) @(negedge clk);
    roll(30, 0, 1, 0, 2, 1, 1, 1, 1, 0, 0, 1);
    drain();
    check("pending", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
